// File: rtl/tcam_req_arbiter.sv
// tcam_req_arbiter
//   Round-robin arbiter that collects requests from NUM_RN request-node
//   ports and queues them in a small FIFO ahead of the TCAM filter stage.
//   Each queued entry carries the request tag, its opcode and a one-hot
//   source node ID.
//
// Parameters
//   WIDTH   tag width in bits (matches the TCAM filter tag)
//   NUM_RN  number of request-node ports
//   DEPTH   FIFO entries (power of two, 2..16)
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   req_valid   per-port request valid
//   req_tag     flattened per-port tags, port i at [i*WIDTH +: WIDTH]
//   req_opcode  flattened per-port opcodes, port i at [i*7 +: 7]
//   req_ready   one-hot (or zero) accept strobe
//   tag         head-of-FIFO tag (zero when empty)
//   opcode      head-of-FIFO opcode (zero when empty)
//   NID         head-of-FIFO one-hot source node ID (zero when empty)
//   out_valid   FIFO holds at least one entry
//   out_ready   downstream accepts the head entry this cycle
//   full        FIFO holds DEPTH entries
//   drop        one-cycle pulse after a request is discarded by the filter
//
// Build option
//   TCAM_ARB_OPCODE_FILTER_EN  when defined, only READ_SHARED (7'b0000001)
//   and READ_UNIQUE (7'b0000111) are queued; other opcodes are consumed,
//   discarded and flagged on drop. When undefined, every opcode is queued
//   and drop is tied low.

module tcam_req_arbiter #(
  parameter int WIDTH  = 33,
  parameter int NUM_RN = 7,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_RN-1:0]       req_valid,
  input  logic [NUM_RN*WIDTH-1:0] req_tag,
  input  logic [NUM_RN*7-1:0]     req_opcode,
  output logic [NUM_RN-1:0]       req_ready,
  output logic [WIDTH-1:0]        tag,
  output logic [6:0]              opcode,
  output logic [6:0]              NID,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    full,
  output logic                    drop
);

  localparam int PW = (NUM_RN > 1) ? $clog2(NUM_RN) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

`ifdef TCAM_ARB_OPCODE_FILTER_EN
  function automatic logic is_forwarded(input logic [6:0] op);
    return (op == 7'b0000001) || (op == 7'b0000111);
  endfunction
`endif

  logic [PW-1:0]    rr_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] mem_tag [DEPTH];
  logic [6:0]       mem_op  [DEPTH];
  logic [6:0]       mem_nid [DEPTH];

  logic [NUM_RN-1:0] fwd_mask;
  logic [NUM_RN-1:0] eligible;
  logic              room;
  logic              pop;
  logic              push;
  logic              grant_vld;
  logic [PW-1:0]     grant_idx;
  logic [6:0]        grant_nid;
  logic [WIDTH-1:0]  grant_tag;
  logic [6:0]        grant_op;
  int                scan_idx;

  assign out_valid = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign pop       = out_valid && out_ready;
  // A pop frees the head slot this cycle, so a full FIFO can still take a push.
  assign room      = !full || pop;

  always_comb begin
    for (int i = 0; i < NUM_RN; i++) begin
`ifdef TCAM_ARB_OPCODE_FILTER_EN
      fwd_mask[i] = is_forwarded(req_opcode[i*7 +: 7]);
`else
      fwd_mask[i] = 1'b1;
`endif
    end
  end

  // Requests that will be discarded never need FIFO space, so they stay
  // eligible even when there is no room.
  assign eligible = req_valid & (room ? {NUM_RN{1'b1}} : ~fwd_mask);

  // Round-robin scan starting at rr_ptr, wrapping past NUM_RN-1.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    for (int k = 0; k < NUM_RN; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NUM_RN) scan_idx = scan_idx - NUM_RN;
      if (!grant_vld && eligible[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = PW'(scan_idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (reset && grant_vld) req_ready[grant_idx] = 1'b1;
  end

  assign grant_nid = 7'd1 << grant_idx;
  assign grant_tag = req_tag[grant_idx*WIDTH +: WIDTH];
  assign grant_op  = req_opcode[grant_idx*7 +: 7];
  assign push      = reset && grant_vld && fwd_mask[grant_idx];

  // Control state: round-robin pointer, FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (grant_vld)
        rr_ptr <= (grant_idx == PW'(NUM_RN - 1)) ? '0 : grant_idx + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage: data only, qualified by the control pointers above.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_tag[wr_ptr] <= grant_tag;
      mem_op[wr_ptr]  <= grant_op;
      mem_nid[wr_ptr] <= grant_nid;
    end
  end

  assign tag    = out_valid ? mem_tag[rd_ptr] : '0;
  assign opcode = out_valid ? mem_op[rd_ptr]  : '0;
  assign NID    = out_valid ? mem_nid[rd_ptr] : '0;

`ifdef TCAM_ARB_OPCODE_FILTER_EN
  logic drop_p1;

  // Discard pulse, registered so it lines up with the queued-path latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_p1 <= 1'b0;
    else        drop_p1 <= grant_vld && !fwd_mask[grant_idx];
  end

  assign drop = drop_p1;
`else
  assign drop = 1'b0;
`endif

endmodule

// File: tb/tb_tcam_req_arbiter.sv
module tb_tcam_req_arbiter;
  localparam int WIDTH  = 33;
  localparam int NUM_RN = 7;
  localparam int DEPTH  = 4;

`ifdef TCAM_ARB_OPCODE_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_RN-1:0]       req_valid;
  logic [NUM_RN*WIDTH-1:0] req_tag;
  logic [NUM_RN*7-1:0]     req_opcode;
  logic [NUM_RN-1:0]       req_ready;
  logic [WIDTH-1:0]        tag;
  logic [6:0]              opcode;
  logic [6:0]              NID;
  logic                    out_valid;
  logic                    out_ready;
  logic                    full;
  logic                    drop;

  tcam_req_arbiter #(.WIDTH(WIDTH), .NUM_RN(NUM_RN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_tag(req_tag),
    .req_opcode(req_opcode), .req_ready(req_ready), .tag(tag),
    .opcode(opcode), .NID(NID), .out_valid(out_valid),
    .out_ready(out_ready), .full(full), .drop(drop)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of expected entries plus the next port to favour.
  typedef struct {
    logic [WIDTH-1:0] t;
    logic [6:0]       op;
    logic [6:0]       nid;
  } entry_t;

  entry_t mq[$];
  int     mrr;
  logic   mdrop;
  int     errors = 0;
  int     checks = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  function automatic bit queued(input logic [6:0] op);
    return !FILT || op == 7'd1 || op == 7'd7;
  endfunction

  function automatic logic [WIDTH-1:0] rand_tag();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[WIDTH-1:0];
  endfunction

  task automatic model_reset();
    mq.delete();
    mrr   = 0;
    mdrop = 1'b0;
  endtask

  // Called at posedge+1 with inputs already driven: check outputs against the
  // model, advance one clock, then update the model with what should happen.
  task automatic step();
    entry_t      h;
    bit          ev, pop, room;
    int          g, p;
    logic [6:0]  op;
    logic [NUM_RN-1:0] er;
    #2;
    ev = (mq.size() > 0);
    if (ev) h = mq[0];
    else    h = '{t: '0, op: '0, nid: '0};
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("tag", 64'(tag), 64'(h.t));
    chk("opcode", 64'(opcode), 64'(h.op));
    chk("NID", 64'(NID), 64'(h.nid));
    chk("full", 64'(full), 64'(mq.size() == DEPTH));
    chk("drop", 64'(drop), 64'(mdrop));
    pop  = ev && out_ready;
    room = (mq.size() < DEPTH) || pop;
    g = -1;
    for (int k = 0; k < NUM_RN; k++) begin
      p  = (mrr + k) % NUM_RN;
      op = req_opcode[p*7 +: 7];
      if (g < 0 && req_valid[p] && (room || !queued(op))) g = p;
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(er));
    @(posedge clk);
    #1;
    if (pop) void'(mq.pop_front());
    mdrop = 1'b0;
    if (g >= 0) begin
      op = req_opcode[g*7 +: 7];
      if (queued(op)) mq.push_back('{t: req_tag[g*WIDTH +: WIDTH], op: op, nid: 7'(1 << g)});
      else            mdrop = 1'b1;
      mrr = (g + 1) % NUM_RN;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] exp_seq [6];
    logic [6:0] ops [4];
    reset      = 1'b0;
    req_valid  = '0;
    req_tag    = '0;
    req_opcode = '0;
    out_ready  = 1'b0;
    model_reset();
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_drop", 64'(drop), 64'd0);
    chk("rst_NID", 64'(NID), 64'd0);
    chk("rst_tag", 64'(tag), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Single request from port 0 on an empty FIFO.
    req_tag[0 +: WIDTH] = 33'hABCDEFF;
    req_opcode[0 +: 7]  = 7'b0000001;
    req_valid           = 7'b0000001;
    step();
    req_valid = '0;
    chk("r32_out_valid", 64'(out_valid), 64'd1);
    chk("r32_tag", 64'(tag), 64'hABCDEFF);
    chk("r32_NID", 64'(NID), 64'b0000001);
    step();
    out_ready = 1'b1;
    step();

    // Ports 1, 2, 6 continuously valid: rotation 1, 2, 6, 1, 2, 6.
    for (int i = 0; i < NUM_RN; i++) begin
      req_opcode[i*7 +: 7]   = 7'b0000001;
      req_tag[i*WIDTH +: WIDTH] = WIDTH'(32'h100 + i);
    end
    exp_seq = '{7'b0000010, 7'b0000100, 7'b1000000,
                7'b0000010, 7'b0000100, 7'b1000000};
    req_valid = 7'b1000110;
    for (int i = 0; i < 6; i++) begin
      #2;
      chk("r33_grant", 64'(req_ready), 64'(exp_seq[i]));
      #1;
      step();
      if (i > 0) chk("r33_nid", 64'(NID), 64'(exp_seq[i]));
    end
    req_valid = '0;
    step();
    step();

    // Back-pressure: fill with out_ready low, then pop and push together.
    out_ready = 1'b0;
    req_valid = 7'b0000001;
    for (int i = 0; i < 4; i++) begin
      req_tag[0 +: WIDTH] = WIDTH'(32'h200 + i);
      step();
    end
    req_tag[0 +: WIDTH] = WIDTH'(32'h204);
    #2;
    chk("r34_full", 64'(full), 64'd1);
    chk("r34_blocked", 64'(req_ready), 64'd0);
    #1;
    step();
    out_ready = 1'b1;
    #2;
    chk("r34_accept_on_pop", 64'(req_ready), 64'd1);
    #1;
    step();
    chk("r34_still_full", 64'(full), 64'd1);
    req_valid = '0;

    // Async reset with three entries buffered.
    step();
    out_ready = 1'b0;
    req_valid = 7'b0101000;
    #2;
    reset = 1'b0;
    #1;
    chk("r35_out_valid", 64'(out_valid), 64'd0);
    chk("r35_full", 64'(full), 64'd0);
    chk("r35_NID", 64'(NID), 64'd0);
    chk("r35_req_ready", 64'(req_ready), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    chk("r35_first_grant", 64'(req_ready), 64'b0001000);
    #1;
    step();
    req_valid = '0;
    out_ready = 1'b1;
    step();
    step();

    // Non-read opcode from port 3.
    req_opcode[3*7 +: 7]      = 7'b0000010;
    req_tag[3*WIDTH +: WIDTH] = WIDTH'(32'h333);
    req_valid = 7'b0001000;
    out_ready = 1'b0;
    #2;
    chk("r36_ready", 64'(req_ready), 64'b0001000);
    #1;
    step();
    req_valid = '0;
    if (FILT) begin
      chk("r36_drop", 64'(drop), 64'd1);
      chk("r36_out_valid", 64'(out_valid), 64'd0);
    end else begin
      chk("r36_NID", 64'(NID), 64'b0001000);
      chk("r36_opcode", 64'(opcode), 64'b0000010);
    end
    step();
    chk("r36_drop_end", 64'(drop), 64'd0);
    out_ready = 1'b1;
    step();

    // Randomized traffic against the model.
    ops = '{7'b0000001, 7'b0000111, 7'b0000010, 7'b0000000};
    for (int c = 0; c < 400; c++) begin
      req_valid = NUM_RN'($urandom());
      for (int i = 0; i < NUM_RN; i++) begin
        req_tag[i*WIDTH +: WIDTH] = rand_tag();
        if ($urandom_range(3) == 0) req_opcode[i*7 +: 7] = 7'($urandom());
        else                        req_opcode[i*7 +: 7] = ops[$urandom_range(2)];
      end
      out_ready = ($urandom_range(2) != 0);
      step();
    end
    req_valid = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
